// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer splitting accesses into aligned memory beats
//
// Accepts one load or store per start strobe and issues it as a series of
// BUS_BYTES-aligned beats on a narrow memory port, with per-lane byte enables.
// Loads are reassembled and sign/zero extended to XLEN bits.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request strobe (taken when not in a beat)
//   sel_mem_operation   1 = store, 0 = load
//   sel_mem_size        log2 of access size in bytes
//   load_unsigned       1 = zero-extend load, 0 = sign-extend
//   addr, data_i        byte address and LSB-aligned store data
//   busy, done, err     beat in progress, completion pulse, illegal-size pulse
//   data_o              load result, held until the next load completes
//   mem_addr            aligned beat address
//   read_mem, write_mem beat direction strobes
//   byte_en, data_mem   active lanes and lane-aligned store data
//   mem_o, mem_ready    lane-aligned load data and beat completion

module mem_access_unit #(
  parameter int XLEN      = 64,
  parameter int ADDR_W    = 64,
  parameter int BUS_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sel_mem_operation,
  input  logic [1:0]             sel_mem_size,
  input  logic                   load_unsigned,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [XLEN-1:0]        data_i,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [XLEN-1:0]        data_o,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   read_mem,
  output logic                   write_mem,
  output logic [BUS_BYTES-1:0]   byte_en,
  output logic [8*BUS_BYTES-1:0] data_mem,
  input  logic [8*BUS_BYTES-1:0] mem_o,
  input  logic                   mem_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BEAT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(BUS_BYTES - 1);
  localparam int IW = $clog2(XLEN);

  logic [1:0]        state;
  logic [ADDR_W-1:0] beat_addr;
  // Request byte index presented on lane 0 of the current beat; negative on
  // the first beat of a misaligned access.
  logic signed [7:0] pos;
  logic [7:0]        n_bytes;
  logic              op_store;
  logic              op_unsigned;
  logic              err_r;
  logic [XLEN-1:0]   st_data;
  logic [XLEN-1:0]   result;
  logic [XLEN-1:0]   result_next;
  int                lane_pos [BUS_BYTES];
  logic              last_beat;
  logic              size_bad;

  assign size_bad  = (XLEN == 32) && (sel_mem_size == 2'd3);
  assign last_beat = (int'(pos) + BUS_BYTES) >= int'(n_bytes);

  assign busy      = (state == S_BEAT);
  assign read_mem  = busy && !op_store;
  assign write_mem = busy && op_store;
  assign mem_addr  = busy ? beat_addr : '0;
  assign done      = (state == S_RESP) && !err_r;
  assign err       = (state == S_RESP) && err_r;

  always_comb begin
    for (int l = 0; l < BUS_BYTES; l++) begin
      lane_pos[l] = int'(pos) + l;
    end
  end

  always_comb begin
    byte_en  = '0;
    data_mem = '0;
    if (state == S_BEAT) begin
      for (int l = 0; l < BUS_BYTES; l++) begin
        if (lane_pos[l] >= 0 && lane_pos[l] < int'(n_bytes)) begin
          byte_en[l] = 1'b1;
          if (op_store) begin
            data_mem[l*8 +: 8] = st_data[IW'(lane_pos[l] * 8) +: 8];
          end
        end
      end
    end
  end

  // Load result with the current beat's lanes merged in; committed only
  // when the beat completes.
  always_comb begin
    result_next = result;
    for (int l = 0; l < BUS_BYTES; l++) begin
      if (byte_en[l] && !op_store) begin
        result_next[IW'(lane_pos[l] * 8) +: 8] = mem_o[l*8 +: 8];
      end
    end
  end

  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                  input logic [7:0]      nb,
                                                  input logic            uns);
    logic [XLEN-1:0] keep;
    logic            sign;
    case (nb)
      8'd1: begin keep = XLEN'(64'hFF);        sign = raw[7];      end
      8'd2: begin keep = XLEN'(64'hFFFF);      sign = raw[15];     end
      8'd4: begin keep = XLEN'(64'hFFFF_FFFF); sign = raw[31];     end
      default: begin keep = '1;                sign = raw[XLEN-1]; end
    endcase
    return (raw & keep) | ((uns || !sign) ? '0 : ~keep);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      beat_addr   <= '0;
      pos         <= '0;
      n_bytes     <= '0;
      op_store    <= 1'b0;
      op_unsigned <= 1'b0;
      err_r       <= 1'b0;
      st_data     <= '0;
      result      <= '0;
      data_o      <= '0;
    end else begin
      case (state)
        // RESP behaves like IDLE for acceptance so back-to-back requests
        // can be taken on the edge that ends the done/err cycle.
        S_IDLE, S_RESP: begin
          if (start) begin
            beat_addr   <= addr & ~LANE_MASK;
            pos         <= 8'd0 - 8'(addr & LANE_MASK);
            n_bytes     <= 8'd1 << sel_mem_size;
            op_store    <= sel_mem_operation;
            op_unsigned <= load_unsigned;
            st_data     <= data_i;
            result      <= '0;
            err_r       <= size_bad;
            state       <= size_bad ? S_RESP : S_BEAT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BEAT: begin
          if (mem_ready) begin
            result <= result_next;
            if (last_beat) begin
              state <= S_RESP;
              if (!op_store) begin
                data_o <= extend_load(result_next, n_bytes, op_unsigned);
              end
            end else begin
              beat_addr <= beat_addr + ADDR_W'(BUS_BYTES);
              pos       <= pos + 8'(BUS_BYTES);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store sequencer between the execute stage and a narrow data memory port. It accepts one load or store request per handshake and splits it into aligned memory beats of `BUS_BYTES` bytes, with per-lane byte enables. Accesses that straddle a bus word, and wait-states via `mem_ready`, are handled without extra logic in the core. Loads return an `XLEN`-wide result with RISC-V sign/zero extension.

## Interface
- `XLEN`, 64: core data width; power of two, 32 or 64.
- `ADDR_W`, 64: address width.
- `BUS_BYTES`, 1: memory port width in bytes; power of two, 1..XLEN/8.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset; asynchronous and active-low.
- `start` in 1: request strobe, sampled only in IDLE.
- `sel_mem_operation` in 1: 1 = store, 0 = load.
- `sel_mem_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = double (3 is illegal when XLEN=32).
- `load_unsigned` in 1: 1 = zero-extend load result, 0 = sign-extend.
- `addr` in ADDR_W: byte address of the access.
- `data_i` in XLEN: store data, LSB-aligned.
- `busy` out 1: high from request accept through the final beat.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse instead of `done` for an illegal size; no memory traffic occurs.
- `data_o` out XLEN: load result; valid from `done` and held until the next accept.
- `mem_addr` out ADDR_W: beat address, always BUS_BYTES-aligned.
- `read_mem` out 1: load beat active.
- `write_mem` out 1: store beat active.
- `byte_en` out BUS_BYTES: active lanes of the current beat.
- `data_mem` out 8*BUS_BYTES: store data, lane-aligned.
- `mem_o` in 8*BUS_BYTES: load data from memory, lane-aligned.
- `mem_ready` in 1: the current beat completes at a rising edge where this is 1.

## Operation
- States: IDLE, BEAT, RESP.
- IDLE:
  - On `start`=1, latch `addr`, size, op, `load_unsigned` and `data_i`.
  - Compute `n = 1 << sel_mem_size` bytes.
  - Compute `off = addr mod BUS_BYTES`.
  - Compute `beats = ceil((off + n) / BUS_BYTES)`.
  - Go to BEAT, or to RESP with `err` if the size is illegal.
- BEAT b (b = 0..beats-1):
  - `mem_addr = align_down(addr) + b*BUS_BYTES`.
  - `byte_en[l] = 1` iff byte `(mem_addr + l - addr)` lies in `[0, n)`.
  - Store: `data_mem` lane l = `data_i` byte `(mem_addr + l - addr)`; inactive lanes are 0.
  - Load: on completion, capture active lanes of `mem_o` into result byte `(mem_addr + l - addr)`.
  - Beat holds all outputs stable while `mem_ready`=0.
  - Last beat completing -> RESP.
- RESP:
  - Pulse `done` (or `err`).
  - Drive `data_o` = extended result, then return to IDLE.
  - Extension: bits above 8n are copied from bit 8n-1 when `load_unsigned`=0, else zero; ignored for full-width loads.
  - `data_o` for a store: unchanged.
- `start` while not IDLE is ignored; no queueing.
- `read_mem`, `write_mem`, `byte_en` and `data_mem` are 0 outside BEAT.

## Timing
- Reset (async assert, deassert sampled on `clk`):
  - State IDLE.
  - `busy`, `done`, `err`, `read_mem`, `write_mem` = 0.
  - `byte_en`, `data_mem`, `mem_addr`, `data_o` = 0.
- Reset mid-beat aborts immediately; no further beat is issued, and partial stores are not rolled back.
- Edge E0 accepts `start`; beat 0 is visible in the cycle after E0.
- Each beat lasts 1 + (wait cycles) clocks.
- `done` is registered on the edge completing the last beat; high for exactly one cycle.
- With `mem_ready`=1, latency from E0 to `done` high = `beats` cycles; `done` at cycle beats+1.
- `busy` rises the cycle after E0 and falls with `done` high. The next `start` is accepted on the edge ending the `done` cycle.
- `err` path: `err` high in the cycle after E0; `busy` never asserts.

## Test plan
- BUS_BYTES=1, load double at 0x100, memory bytes 0x01..0x08, `mem_ready`=1:
  - 8 beats at 0x100..0x107.
  - `done` at cycle 9.
  - `data_o`=0x0807060504030201.
- BUS_BYTES=4, store half 0xBEEF at 0x203:
  - Beat0 `mem_addr`=0x200, `byte_en`=4'b1000, `data_mem`=0xEF000000.
  - Beat1 `mem_addr`=0x204, `byte_en`=4'b0001, `data_mem`=0x000000BE.
  - `done` at cycle 3.
- BUS_BYTES=4, load byte 0x80 at 0x11:
  - `load_unsigned`=0 gives `data_o`=0xFFFFFFFFFFFFFF80.
  - `load_unsigned`=1 gives `data_o`=0x80.
  - One beat each, `byte_en`=4'b0010.
- Load word with 3 wait cycles per beat (BUS_BYTES=2):
  - Outputs are stable during waits.
  - `done` at cycle 9.
  - `start` pulses while busy are ignored.
- `rst_n` low during beat 2 of an 8-beat store:
  - All outputs 0 asynchronously.
  - No `done`.
  - Next request after reset completes normally.
- XLEN=32, `sel_mem_size`=3:
  - `err` pulse in cycle 1.
  - No `read_mem`/`write_mem`.
  - `busy` stays 0.
